// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - RV32I/M instruction decode stage with registered output and load-use bubble
module decode_ctrl #(
    parameter bit M_EXT     = 1'b0,
    parameter int ALUOP_W   = 5,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [3:0]         out_type,
    output logic               out_memtoreg,
    output logic               out_regwrite,
    output logic               out_memwrite,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic               out_illegal
);

    typedef enum logic {RUN, BUBBLE} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state, state_next;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        alt;
    logic [4:0]  arith_op;
    logic [4:0]  d_op;
    logic [3:0]  d_type;
    logic        d_memtoreg, d_regwrite, d_memwrite, d_illegal;
    logic        use_rs1, use_rs2;
    logic        load_flag;
    logic [4:0]  load_rd;
    logic        accept, hazard;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // funct7[5] selects sub/sra for register ops but only sra for immediate ops
    assign alt = funct7[5] & ((opcode == OP_R) | (funct3 == 3'b101));

    always_comb begin
        arith_op = 5'd10;
        case (funct3)
            3'b000:  arith_op = alt ? 5'd2 : 5'd1;
            3'b001:  arith_op = 5'd3;
            3'b010:  arith_op = 5'd4;
            3'b011:  arith_op = 5'd5;
            3'b100:  arith_op = 5'd6;
            3'b101:  arith_op = alt ? 5'd8 : 5'd7;
            3'b110:  arith_op = 5'd9;
            default: arith_op = 5'd10;
        endcase
    end

    always_comb begin
        d_op       = 5'd0;
        d_type     = 4'd0;
        d_memtoreg = 1'b0;
        d_regwrite = 1'b0;
        d_memwrite = 1'b0;
        d_illegal  = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000001 && !M_EXT) begin
                    d_illegal = 1'b1;
                end else begin
                    d_op       = (funct7 == 7'b0000001) ? 5'd21 + {2'b00, funct3} : arith_op;
                    d_type     = 4'd1;
                    d_regwrite = 1'b1;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
            end
            OP_I: begin
                d_op       = arith_op;
                d_type     = (funct3 == 3'b001 || funct3 == 3'b101) ? 4'd7 : 4'd2;
                d_regwrite = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_LOAD: begin
                d_op       = 5'd1;
                d_type     = 4'd2;
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_STORE: begin
                d_op       = 5'd1;
                d_type     = 4'd3;
                d_memwrite = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_op    = (funct3[2] ? 5'd9 : 5'd11) + {2'b00, funct3};
                    d_type  = 4'd4;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_AUIPC: begin
                d_op       = 5'd17;
                d_type     = 4'd5;
                d_regwrite = 1'b1;
            end
            OP_LUI: begin
                d_op       = 5'd18;
                d_type     = 4'd8;
                d_regwrite = 1'b1;
            end
            OP_JALR: begin
                d_op       = 5'd19;
                d_type     = 4'd9;
                d_regwrite = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_JAL: begin
                d_op       = 5'd20;
                d_type     = 4'd6;
                d_regwrite = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign in_ready = (~out_valid | out_ready) & (state == RUN);
    assign accept   = in_valid & in_ready & ~flush;
    assign hazard   = HAZARD_EN && load_flag && (load_rd != 5'd0) &&
                      ((use_rs1 && rs1 == load_rd) || (use_rs2 && rs2 == load_rd));

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && hazard) state_next = BUBBLE;
            BUBBLE:  state_next = RUN;
            default: state_next = RUN;
        endcase
        if (flush) state_next = RUN;
    end

    // A hazarded instruction is captured immediately but only marked valid after the bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_aluop    <= '0;
            out_type     <= 4'd0;
            out_memtoreg <= 1'b0;
            out_regwrite <= 1'b0;
            out_memwrite <= 1'b0;
            out_rd       <= 5'd0;
            out_rs1      <= 5'd0;
            out_rs2      <= 5'd0;
            out_illegal  <= 1'b0;
            load_flag    <= 1'b0;
            load_rd      <= 5'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
            load_flag <= 1'b0;
        end else if (state == BUBBLE) begin
            out_valid <= 1'b1;
            load_flag <= 1'b0;
        end else if (accept) begin
            out_valid    <= ~hazard;
            out_aluop    <= ALUOP_W'(d_op);
            out_type     <= d_type;
            out_memtoreg <= d_memtoreg;
            out_regwrite <= d_regwrite;
            out_memwrite <= d_memwrite;
            out_rd       <= rd;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_illegal  <= d_illegal;
            load_flag    <= (opcode == OP_LOAD);
            load_rd      <= rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - scoreboard bench for decode_ctrl, two parameterisations on shared stimulus
module tb_decode_ctrl;

    typedef struct packed {
        logic [4:0] aluop;
        logic [3:0] typ;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } bundle_t;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready     [2];
    logic        out_valid    [2];
    logic [4:0]  out_aluop    [2];
    logic [3:0]  out_type     [2];
    logic        out_memtoreg [2];
    logic        out_regwrite [2];
    logic        out_memwrite [2];
    logic [4:0]  out_rd       [2];
    logic [4:0]  out_rs1      [2];
    logic [4:0]  out_rs2      [2];
    logic        out_illegal  [2];

    // dut 0: M extension on, bubbles on; dut 1: M off, bubbles off
    bit m_ext_of [2] = '{1'b1, 1'b0};
    bit haz_of   [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    decode_ctrl #(.M_EXT(1'b1), .ALUOP_W(5), .HAZARD_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_aluop(out_aluop[0]), .out_type(out_type[0]), .out_memtoreg(out_memtoreg[0]),
        .out_regwrite(out_regwrite[0]), .out_memwrite(out_memwrite[0]), .out_rd(out_rd[0]),
        .out_rs1(out_rs1[0]), .out_rs2(out_rs2[0]), .out_illegal(out_illegal[0])
    );

    decode_ctrl #(.M_EXT(1'b0), .ALUOP_W(5), .HAZARD_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_aluop(out_aluop[1]), .out_type(out_type[1]), .out_memtoreg(out_memtoreg[1]),
        .out_regwrite(out_regwrite[1]), .out_memwrite(out_memwrite[1]), .out_rd(out_rd[1]),
        .out_rs1(out_rs1[1]), .out_rs2(out_rs2[1]), .out_illegal(out_illegal[1])
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference decode tables, indexed by funct3
    int r_tbl  [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
    int br_tbl [8] = '{11, 12, -1, -1, 13, 14, 15, 16};

    function automatic bundle_t ref_decode(input logic [31:0] ins, input bit mext);
        bundle_t b;
        int f3;
        logic [6:0] op;
        op = ins[6:0];
        f3 = int'(ins[14:12]);
        b = '0;
        b.rd  = ins[11:7];
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        if (op == 7'h33 && ins[31:25] == 7'h01) begin
            if (mext) begin b.aluop = 5'(21 + f3); b.typ = 1; b.regwrite = 1; end
            else b.illegal = 1;
        end else if (op == 7'h33) begin
            b.aluop = 5'(r_tbl[f3] + ((ins[30] && (f3 == 0 || f3 == 5)) ? 1 : 0));
            b.typ = 1; b.regwrite = 1;
        end else if (op == 7'h13) begin
            b.aluop = 5'(r_tbl[f3] + ((ins[30] && f3 == 5) ? 1 : 0));
            b.typ = (f3 == 1 || f3 == 5) ? 4'd7 : 4'd2;
            b.regwrite = 1;
        end else if (op == 7'h03) begin
            b.aluop = 1; b.typ = 2; b.memtoreg = 1; b.regwrite = 1;
        end else if (op == 7'h23) begin
            b.aluop = 1; b.typ = 3; b.memwrite = 1;
        end else if (op == 7'h63 && br_tbl[f3] > 0) begin
            b.aluop = 5'(br_tbl[f3]); b.typ = 4;
        end else if (op == 7'h17) begin
            b.aluop = 17; b.typ = 5; b.regwrite = 1;
        end else if (op == 7'h37) begin
            b.aluop = 18; b.typ = 8; b.regwrite = 1;
        end else if (op == 7'h67) begin
            b.aluop = 19; b.typ = 9; b.regwrite = 1;
        end else if (op == 7'h6F) begin
            b.aluop = 20; b.typ = 6; b.regwrite = 1;
        end else begin
            b.illegal = 1;
        end
        return b;
    endfunction

    function automatic bit reads_reg(input bundle_t b, input logic [4:0] r);
        bit two_src, one_src;
        two_src = (b.typ == 1 || b.typ == 3 || b.typ == 4);
        one_src = (b.typ == 2 || b.typ == 7 || b.typ == 9);
        return ((two_src || one_src) && b.rs1 == r) || (two_src && b.rs2 == r);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11] = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        w[6:0]   = (k < 11) ? ops[k] : 7'($urandom);
        w[31:25] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // behavioural model state per DUT
    bit         m_ov    [2];
    bit         m_bub   [2];
    bit         m_rec_v [2];
    logic [4:0] m_rec_rd[2];
    bundle_t    q0[$];
    bundle_t    q1[$];
    bit         mon_en = 1'b0;

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 0; m_bub[d] = 0; m_rec_v[d] = 0; m_rec_rd[d] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                bundle_t act, exp;
                int qs;
                chk(out_valid[d] == m_ov[d], $sformatf("out_valid[%0d]", d), 64'(out_valid[d]), 64'(m_ov[d]));
                if (out_valid[d]) begin
                    act = '{out_aluop[d], out_type[d], out_memtoreg[d], out_regwrite[d],
                            out_memwrite[d], out_illegal[d], out_rd[d], out_rs1[d], out_rs2[d]};
                    qs = (d == 0) ? q0.size() : q1.size();
                    if (qs == 0) begin
                        chk(1'b0, $sformatf("bundle_unexpected[%0d]", d), 64'(act), 64'(0));
                    end else begin
                        exp = (d == 0) ? q0[0] : q1[0];
                        chk(act == exp, $sformatf("bundle[%0d]", d), 64'(act), 64'(exp));
                        if (out_ready) begin
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
        #2;
        for (int d = 0; d < 2; d++) begin
            bit exp_ir, acc, hz;
            bundle_t e;
            exp_ir = (!m_ov[d] || ordy) && !m_bub[d];
            chk(in_ready[d] == exp_ir, $sformatf("in_ready[%0d]", d), 64'(in_ready[d]), 64'(exp_ir));
            acc = v && exp_ir && !fl;
            if (fl) begin
                m_ov[d] = 0; m_bub[d] = 0; m_rec_v[d] = 0;
                if (d == 0) q0.delete(); else q1.delete();
            end else if (m_bub[d]) begin
                m_ov[d] = 1; m_bub[d] = 0; m_rec_v[d] = 0;
            end else if (acc) begin
                e = ref_decode(ins, m_ext_of[d]);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                hz = haz_of[d] && m_rec_v[d] && m_rec_rd[d] != 0 && reads_reg(e, m_rec_rd[d]);
                m_rec_v[d]  = (ins[6:0] == 7'h03);
                m_rec_rd[d] = ins[11:7];
                m_bub[d] = hz;
                m_ov[d]  = !hz;
            end else if (ordy) begin
                m_ov[d] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [63:0] flds;
            flds = 64'({out_aluop[d], out_type[d], out_memtoreg[d], out_regwrite[d], out_memwrite[d],
                        out_illegal[d], out_rd[d], out_rs1[d], out_rs2[d]});
            chk(out_valid[d] == 1'b0, $sformatf("rst_out_valid[%0d]", d), 64'(out_valid[d]), 64'(0));
            chk(flds == 64'(0), $sformatf("rst_fields[%0d]", d), flds, 64'(0));
            chk(in_ready[d] == 1'b1, $sformatf("rst_in_ready[%0d]", d), 64'(in_ready[d]), 64'(1));
        end
        mon_en = 1'b1;
    endtask

    stim_t dir[$];

    initial begin
        // add; lw x5; add x6,x5,x2 (load-use); mul; hold 3 cycles; release; flush during hold
        dir.push_back('{1'b1, 32'h002081B3, 1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h0000A283, 1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h00228333, 1'b1, 1'b0});
        dir.push_back('{1'b0, 32'h0,        1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h022081B3, 1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h40208133, 1'b0, 1'b0});
        dir.push_back('{1'b1, 32'h40208133, 1'b0, 1'b0});
        dir.push_back('{1'b1, 32'h40208133, 1'b0, 1'b0});
        dir.push_back('{1'b1, 32'h40208133, 1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h0020A023, 1'b1, 1'b0});
        dir.push_back('{1'b1, 32'h00B52063, 1'b0, 1'b0});
        dir.push_back('{1'b1, 32'h0000A263, 1'b0, 1'b1});
        dir.push_back('{1'b0, 32'h0,        1'b1, 1'b0});

        do_reset();
        foreach (dir[i]) step(dir[i].v, dir[i].ins, dir[i].ordy, dir[i].fl);

        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0);
        end

        // reset while a bundle is held and a load-use bubble may be pending
        step(1'b1, 32'h0000A283, 1'b1, 1'b0);
        step(1'b1, 32'h00228333, 1'b0, 1'b0);
        step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 200; c++) begin
            step($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 3) != 0, 1'b0);
        end

        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        chk(q0.size() == 0, "drain_q0", 64'(q0.size()), 64'(0));
        chk(q1.size() == 0, "drain_q1", 64'(q1.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter M_EXT, default 0: 1 enables RV32M decode (opcode 0110011, funct7 0000001); 0 flags those encodings illegal.
REQ-002 Parameter ALUOP_W, default 5: ALU operation code width; SHALL be at least 5.
REQ-003 Parameter HAZARD_EN, default 1: 1 enables load-use bubble insertion; 0 disables it.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  in_instr holds a valid instruction.
REQ-007 in_ready  out  1  block accepts in_instr this cycle.
REQ-008 in_instr  in  32  raw RV32 instruction word.
REQ-009 flush  in  1  discard held and incoming instructions.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  downstream accepts bundle.
REQ-012 out_aluop  out  ALUOP_W  ALU op: nop 0, add 1, sub 2, sll 3, slt 4, sltu 5, xor 6, srl 7, sra 8, or 9, and 10, beq..bgeu 11-16, auipc 17, lui 18, jalr 19, jal 20, mul..remu 21-28.
REQ-013 out_type  out  4  format: R 1, I 2, S 3, B 4, AUIPC 5, JAL 6, shift-imm 7, LUI 8, JALR 9, none 0.
REQ-014 out_memtoreg, out_regwrite, out_memwrite  out  1 each  datapath controls.
REQ-015 out_rd, out_rs1, out_rs2  out  5 each  register fields of in_instr[11:7], [19:15], [24:20].
REQ-016 out_illegal  out  1  unsupported opcode/funct combination.

Function
REQ-017 Decode SHALL match the existing RV32I controller mapping for every RV32I opcode/funct3/funct7[5]; loads set memtoreg=1, regwrite=1, aluop=1.
REQ-018 M_EXT=1: funct7=0000001 with R opcode SHALL give aluop 21+funct3, type 1, regwrite=1.
REQ-019 Illegal encodings (unknown opcode, branch funct3 010/011, M op with M_EXT=0) SHALL set out_illegal=1 with regwrite=memwrite=memtoreg=0, aluop=0, type=0.
REQ-020 Outputs SHALL be registered; latency in_valid&in_ready to out_valid is exactly one cycle.
REQ-021 in_ready SHALL equal (~out_valid | out_ready) & (state==RUN).
REQ-022 Bundle held stable while out_valid=1 and out_ready=0.
REQ-023 FSM states RUN, BUBBLE; RUN->BUBBLE when HAZARD_EN=1, accepting an instruction with rs1 or rs2 (per its format) equal to last accepted load's rd, rd!=0, and that load accepted in the immediately preceding accept; BUBBLE->RUN after exactly one cycle.
REQ-024 In BUBBLE, in_ready=0 and out_valid=0 for one cycle; the held instruction then issues with the load record cleared.
REQ-025 Load record (rd, flag) SHALL update on every accept; non-load accept clears flag.
REQ-026 flush SHALL clear out_valid, load record and state to RUN next cycle; flush has priority over simultaneous accept, which is dropped.
REQ-027 Simultaneous out_ready and in_valid with out_valid=1 SHALL pass through without a gap.

Reset
REQ-028 rst SHALL force out_valid=0, state RUN, load flag 0, all out_* fields 0; in_ready=1 in the first cycle after rst deasserts.
REQ-029 rst mid-stall or mid-hold SHALL discard all in-flight instructions.

Verification
REQ-030 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, aluop=1, type=1, regwrite=1, rd=3.
REQ-031 lw x5,0(x1) then add x6,x5,x2 back-to-back -> one bubble cycle (in_ready=0, out_valid=0), add issues 2 cycles after lw.
REQ-032 Same sequence with HAZARD_EN=0 -> no bubble, consecutive issue.
REQ-033 mul x3,x1,x2 (0x022081B3): M_EXT=1 -> aluop=21; M_EXT=0 -> out_illegal=1, regwrite=0.
REQ-034 out_ready=0 for 3 cycles with valid bundle -> bundle stable, in_ready=0; release -> next instruction follows without gap.
REQ-035 flush asserted with in_valid=1 during held bundle -> next cycle out_valid=0, state RUN, instruction dropped.
